// File: rtl/sobel_pkg.sv
// Shared encodings and helpers for the streaming Sobel filter.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_GX     = 2'b00,
        MODE_GY     = 2'b01,
        MODE_MAG    = 2'b10,
        MODE_THRESH = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        RUN  = 2'b10
    } state_e;

    // Four extra bits cover the 1-2-1 kernel gain and the sign of Gx/Gy.
    function automatic int out_width(input int pix_w);
        return pix_w + 4;
    endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / result-out handshake bundle of the Sobel filter.
// master = pixel source plus result sink, slave = the filter.
interface sobel_stream_if #(
    parameter int PIX_W = 8
);
    import sobel_pkg::*;

    localparam int OUT_W = out_width(PIX_W);

    logic [PIX_W-1:0] Din;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [OUT_W-2:0] thresh;
    logic [OUT_W-1:0] Dout;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             fill_now;
    logic             frame_done;

    modport master (
        output Din, in_valid, mode, thresh, out_ready,
        input  in_ready, Dout, out_valid, out_last, fill_now, frame_done
    );

    modport slave (
        input  Din, in_valid, mode, thresh, out_ready,
        output in_ready, Dout, out_valid, out_last, fill_now, frame_done
    );

endinterface

// File: rtl/sobel_line_buf.sv
// One-line delay: reads the word stored at addr and overwrites it in the same cycle.
// Latency: read is combinational, the write lands on the enabled clock edge.
// Backpressure: none of its own; en is the owner's accept strobe.
module sobel_line_buf #(
    parameter int DEPTH = 1280,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wr_dat,
    output logic [W-1:0]             rd_dat
);

    // Contents are not reset: a frame's two fill rows overwrite every word before use.
    logic [W-1:0] mem [DEPTH];

    assign rd_dat = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter over raster pixels; one result per interior pixel.
// Latency: result registered one cycle after the accept of its bottom-right pixel.
// Backpressure: in_ready = !out_valid || out_ready; a held result freezes everything.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720,
    parameter int PIX_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    sobel_stream_if.slave bus
);

    localparam int OUT_W = out_width(PIX_W);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } col_t;

    state_e           state_q, state_d;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    mode_e            mode_q;
    logic [OUT_W-2:0] thresh_q;
    logic             out_valid_q, out_last_q;
    logic [OUT_W-1:0] dout_q;

    logic             accept, emit, col_wrap, frame_end;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;
    col_t             win_l, win_m, col_new;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;
    assign col_wrap       = (col_q == COL_LAST);
    assign frame_end      = col_wrap && (row_q == ROW_LAST);
    assign emit           = accept && (state_q == RUN) && (col_q >= CW'(2));

    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.Dout       = dout_q;
    assign bus.fill_now   = (state_q == IDLE);
    assign bus.frame_done = out_valid_q && bus.out_ready && out_last_q;

    // lb1 delays Din by one line, lb2 delays lb1 by another.
    sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
        .clk    (clk),
        .en     (accept),
        .addr   (col_q),
        .wr_dat (bus.Din),
        .rd_dat (lb1_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb2 (
        .clk    (clk),
        .en     (accept),
        .addr   (col_q),
        .wr_dat (lb1_rd),
        .rd_dat (lb2_rd)
    );

    assign col_new = {lb2_rd, lb1_rd, bus.Din};

    always_ff @(posedge clk) begin
        if (accept) begin
            win_l <= win_m;
            win_m <= col_new;
        end
    end

    function automatic logic signed [OUT_W-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'(OUT_W'(p));
    endfunction

    logic signed [OUT_W-1:0] gx, gy, ax, ay, mag;
    logic        [OUT_W-1:0] res;

    always_comb begin
        gx  = (ext(col_new.top) + (ext(col_new.mid) <<< 1) + ext(col_new.bot))
            - (ext(win_l.top)   + (ext(win_l.mid)   <<< 1) + ext(win_l.bot));
        gy  = (ext(win_l.top) + (ext(win_m.top) <<< 1) + ext(col_new.top))
            - (ext(win_l.bot) + (ext(win_m.bot) <<< 1) + ext(col_new.bot));
        ax  = gx[OUT_W-1] ? -gx : gx;
        ay  = gy[OUT_W-1] ? -gy : gy;
        mag = ax + ay;
        res = '0;
        case (mode_q)
            MODE_GX:  res = gx;
            MODE_GY:  res = gy;
            MODE_MAG: res = mag;
            default:  res = (unsigned'(mag) >= {1'b0, thresh_q}) ? '1 : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FILL;
            FILL:    if (accept && col_wrap && row_q == RW'(1)) state_d = RUN;
            RUN:     if (accept && frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_GX;
            thresh_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            dout_q      <= '0;
        end else begin
            if (accept) begin
                col_q <= col_wrap ? '0 : col_q + 1'b1;
                if (col_wrap) begin
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end
                // Frame settings are sampled only with the first pixel of a frame.
                if (state_q == IDLE) begin
                    mode_q   <= mode_e'(bus.mode);
                    thresh_q <= bus.thresh;
                end
            end
            if (emit) begin
                out_valid_q <= 1'b1;
                out_last_q  <= frame_end;
                dout_q      <= res;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: table-driven known frames, stall/reset/back-to-back sequences,
// and randomized frames checked against a direct 3x3 convolution model.
module tb_sobel_stream;

    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int PIX_W = 8;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sobel_stream_if #(.PIX_W(PIX_W)) bus ();

    sobel_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int pat;
        int mode;
        int thr;
        int exp_v [NRES];
    } vec_t;

    vec_t tbl [12];

    int checks   = 0;
    int failures = 0;

    logic [PIX_W-1:0] frame [IMG_H][IMG_W];
    int f_mode, f_thresh;
    int got_dat[$];
    int got_last[$];
    int exp_q[$];
    int done_cnt;

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, exp_v);
        end
    endtask

    function automatic void setv(input int i, input int pat, input int mode, input int thr,
                                 input int e0, input int e1, input int e2,
                                 input int e3, input int e4, input int e5);
        tbl[i].pat = pat;
        tbl[i].mode = mode;
        tbl[i].thr = thr;
        tbl[i].exp_v[0] = e0; tbl[i].exp_v[1] = e1; tbl[i].exp_v[2] = e2;
        tbl[i].exp_v[3] = e3; tbl[i].exp_v[4] = e4; tbl[i].exp_v[5] = e5;
    endfunction

    // 0: flat 100, 1: vertical edge, 2: bright top row, 3: bright left column, else random
    function automatic void load_pattern(input int pat);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                case (pat)
                    0: frame[r][c] = 8'd100;
                    1: frame[r][c] = (c >= 2) ? 8'd10 : 8'd0;
                    2: frame[r][c] = (r == 0) ? 8'd50 : 8'd0;
                    3: frame[r][c] = (c == 0) ? 8'd255 : 8'd0;
                    default: frame[r][c] = 8'($urandom_range(3) == 0 ? 255 * $urandom_range(1) : $urandom_range(255));
                endcase
            end
        end
    endfunction

    function automatic int px(input int r, input int c);
        return int'(frame[r][c]);
    endfunction

    // Textbook Sobel at centre (r,c), reduced to the 12-bit output word.
    function automatic int ref_result(input int mode, input int thr, input int r, input int c);
        int gx, gy, mag, wt;
        gx = 0;
        gy = 0;
        for (int d = -1; d <= 1; d++) begin
            wt = (d == 0) ? 2 : 1;
            gx += wt * (px(r + d, c + 1) - px(r + d, c - 1));
            gy += wt * (px(r - 1, c + d) - px(r + 1, c + d));
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        case (mode)
            0: return gx & 12'hFFF;
            1: return gy & 12'hFFF;
            2: return mag;
            default: return (mag >= thr) ? 12'hFFF : 0;
        endcase
    endfunction

    function automatic void build_model(input int nframes);
        exp_q.delete();
        for (int f = 0; f < nframes; f++)
            for (int r = 1; r < IMG_H - 1; r++)
                for (int c = 1; c < IMG_W - 1; c++)
                    exp_q.push_back(ref_result(f_mode, f_thresh, r, c));
    endfunction

    task automatic stream(input int nframes, input int vgap, input int rgap,
                          input bit scramble, input bit stall2, input int max_cycles);
        int sent, cyc, stall_left, idx, extra;
        bit stall_done;
        int held;
        sent = 0; cyc = 0; stall_left = 0; stall_done = 0; held = 0; extra = 0;
        got_dat.delete();
        got_last.delete();
        done_cnt = 0;
        while (got_dat.size() < nframes * NRES && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            idx = sent % NPIX;
            if (sent < nframes * NPIX) begin
                bus.in_valid = ($urandom_range(99) >= vgap);
                bus.Din = frame[idx / IMG_W][idx % IMG_W];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (scramble && idx != 0) begin
                bus.mode = 2'($urandom);
                bus.thresh = 11'($urandom);
            end else begin
                bus.mode = 2'(f_mode);
                bus.thresh = 11'(f_thresh);
            end
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
            end else if (stall2 && !stall_done && bus.out_valid && got_dat.size() == 1) begin
                stall_left = 3;
                held = int'(bus.Dout);
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = ($urandom_range(99) >= rgap);
            end
            #1;
            if (stall_left > 0) begin
                chk("stall_in_ready", int'(bus.in_ready), 0);
                chk("stall_dout_held", int'(bus.Dout), held);
                chk("stall_out_valid", int'(bus.out_valid), 1);
                stall_left--;
                if (stall_left == 0) stall_done = 1;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                got_dat.push_back(int'(bus.Dout));
                got_last.push_back(int'(bus.out_last));
            end
            if (bus.frame_done) done_cnt++;
        end
        if (cyc >= max_cycles) chk("stream_timeout", cyc, -1);
        if (stall2) chk("stall_happened", int'(stall_done), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) extra++;
        end
        chk("no_extra_results", extra, 0);
        chk("fill_now_after", int'(bus.fill_now), 1);
    endtask

    task automatic check_results(input string tag, input int nframes);
        chk({tag, "_count"}, got_dat.size(), exp_q.size());
        for (int i = 0; i < got_dat.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_dout[%0d]", tag, i), got_dat[i], exp_q[i]);
            chk($sformatf("%s_last[%0d]", tag, i), got_last[i], int'(i % NRES == NRES - 1));
        end
        chk({tag, "_frame_done"}, done_cnt, nframes);
    endtask

    initial begin
        int n, guard;
        setv(0,  0, 0, 1,    0, 0, 0, 0, 0, 0);
        setv(1,  0, 1, 1,    0, 0, 0, 0, 0, 0);
        setv(2,  0, 2, 1,    0, 0, 0, 0, 0, 0);
        setv(3,  0, 3, 1,    0, 0, 0, 0, 0, 0);
        setv(4,  1, 0, 1,    40, 40, 0, 40, 40, 0);
        setv(5,  1, 1, 1,    0, 0, 0, 0, 0, 0);
        setv(6,  2, 1, 1,    200, 200, 200, 0, 0, 0);
        setv(7,  2, 2, 1,    200, 200, 200, 0, 0, 0);
        setv(8,  3, 0, 1,    3076, 0, 0, 3076, 0, 0);
        setv(9,  3, 2, 1,    1020, 0, 0, 1020, 0, 0);
        setv(10, 3, 3, 1020, 4095, 0, 0, 4095, 0, 0);
        setv(11, 3, 3, 1021, 0, 0, 0, 0, 0, 0);

        bus.Din = '0;
        bus.in_valid = 1'b0;
        bus.mode = 2'd0;
        bus.thresh = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_dout", int'(bus.Dout), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        chk("rst_fill_now", int'(bus.fill_now), 1);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        rst = 1'b0;

        for (int t = 0; t < 12; t++) begin
            load_pattern(tbl[t].pat);
            f_mode = tbl[t].mode;
            f_thresh = tbl[t].thr;
            stream(1, 0, 0, 1'b0, 1'b0, 500);
            exp_q.delete();
            for (int i = 0; i < NRES; i++) exp_q.push_back(tbl[t].exp_v[i]);
            check_results($sformatf("vec%0d", t), 1);
        end

        // Downstream stall on the second result.
        load_pattern(1);
        f_mode = 0;
        f_thresh = 1;
        stream(1, 0, 0, 1'b0, 1'b1, 500);
        exp_q = '{40, 40, 0, 40, 40, 0};
        check_results("stall", 1);

        // Reset after 7 pixels, then a clean frame.
        load_pattern(0);
        f_mode = 2;
        n = 0;
        guard = 0;
        while (n < 7 && guard < 100) begin
            @(negedge clk);
            guard++;
            bus.in_valid = 1'b1;
            bus.Din = frame[n / IMG_W][n % IMG_W];
            bus.mode = 2'(f_mode);
            bus.out_ready = 1'b1;
            #1;
            if (bus.in_ready) n++;
        end
        chk("midrst_pixels_sent", n, 7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_fill_now", int'(bus.fill_now), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        stream(1, 0, 0, 1'b0, 1'b0, 500);
        exp_q = '{0, 0, 0, 0, 0, 0};
        check_results("midrst", 1);

        // Back-to-back frames with in_valid held high.
        stream(2, 0, 0, 1'b0, 1'b0, 1000);
        build_model(2);
        check_results("b2b", 2);

        // Random frames, random gaps, mode/thresh wiggled mid-frame.
        for (int k = 0; k < 6; k++) begin
            load_pattern(9);
            f_mode = $urandom_range(3);
            f_thresh = $urandom_range(2047);
            stream(1, 30, 30, 1'b1, 1'b0, 3000);
            build_model(1);
            check_results($sformatf("rand%0d", k), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
